// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, parity modes, default bit period,
// parity check and 2-of-3 vote functions.
package uart_pkg;

    localparam int CLK_DIV_DFLT  = 868;
    localparam int PAR_NONE      = 0;
    localparam int PAR_ODD       = 1;
    localparam int PAR_EVEN      = 2;
    localparam int UART_MAX_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } uart_state_e;

    // Returns 1 when data plus received parity bit violate the selected mode
    function automatic logic par_bad(input logic [UART_MAX_BITS-1:0] data,
                                     input logic                     pbit,
                                     input logic                     odd);
        logic x;
        x = (^data) ^ pbit;
        return odd ? ~x : x;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with a registered sample strobe at a fixed phase,
// restartable by a synchronous clear. Shared by the UART receiver and transmitter.
module uart_bit_timer import uart_pkg::*; #(
    parameter int CLK_DIV = CLK_DIV_DFLT,
    parameter int STB_AT  = CLK_DIV / 2,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             stb
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stb_r;

    // Next count: restart on clear, wrap after CLK_DIV-1
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Counter and strobe registers; strobe is high exactly while cnt == STB_AT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            stb_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            stb_r <= (cnt_nxt_s == CNT_W'(STB_AT));
        end
    end

    assign cnt = cnt_r;
    assign stb = stb_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with synchroniser, glitch-rejecting start detection,
// parity/framing flags and a valid/ready output with overrun. Optional: UART_RX_MAJORITY_EN.
module uart_rx_param import uart_pkg::*; #(
    parameter int CLK_DIV   = CLK_DIV_DFLT,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rx_rdy,
    output logic                 rx_vld,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_ovr
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [1:0]           sync_r;
    logic                 rx_s;
    logic                 rx_prev_r;
    logic [CNT_W-1:0]     cnt_s;
    logic                 stb_s;
    logic                 clr_s;
    logic                 bit_s;
    uart_state_e          state_r;
    uart_state_e          state_nxt_s;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 fperr_r;
    logic                 fferr_r;
    logic                 done_r;
    logic                 data_last_s;
    logic                 stop_last_s;
    logic                 vld_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 ovr_r;

    // Two-flop synchroniser plus one history flop for edge detection, preset to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], rx};
            rx_prev_r <= sync_r[1];
        end
    end

    assign rx_s = sync_r[1];

`ifdef UART_RX_MAJORITY_EN
    localparam int STB_AT = CLK_DIV / 2 + 1;
    logic [1:0] tap_r;

    // Capture the two early taps; the strobe cycle supplies the third vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_r <= 2'b11;
        end else begin
            tap_r[0] <= (cnt_s == CNT_W'(CLK_DIV / 2 - 1)) ? rx_s : tap_r[0];
            tap_r[1] <= (cnt_s == CNT_W'(CLK_DIV / 2))     ? rx_s : tap_r[1];
        end
    end

    assign bit_s = maj3(tap_r[0], tap_r[1], rx_s);
`else
    localparam int STB_AT = CLK_DIV / 2;
    logic cnt_unused_s;

    assign cnt_unused_s = ^cnt_s;
    assign bit_s        = rx_s;
`endif

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV),
        .STB_AT  (STB_AT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .cnt   (cnt_s),
        .stb   (stb_s)
    );

    assign data_last_s = (bit_cnt_r == 4'(DATA_BITS - 1));
    assign stop_last_s = (bit_cnt_r == 4'(STOP_BITS - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; only a 1->0 transition starts a frame, so a stuck-low line stays idle
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_prev_r && !rx_s) begin
                    state_nxt_s = ST_START;
                    clr_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!stb_s) begin
                    state_nxt_s = ST_START;
                end else if (bit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (stb_s && data_last_s) begin
                    if (PARITY != PAR_NONE) begin
                        state_nxt_s = ST_PAR;
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (stb_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (stb_s && stop_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                clr_s       = 1'b0;
            end
        endcase
    end

    // Per-frame datapath: bit counter, shift register, error capture, completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            fperr_r   <= 1'b0;
            fferr_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 4'd0;
                end
                ST_START: begin
                    if (stb_s) begin
                        bit_cnt_r <= 4'd0;
                        fperr_r   <= 1'b0;
                        fferr_r   <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (stb_s) begin
                        shift_r   <= {bit_s, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= data_last_s ? 4'd0 : bit_cnt_r + 4'd1;
                    end
                end
                ST_PAR: begin
                    if (stb_s) begin
                        fperr_r <= par_bad(UART_MAX_BITS'(shift_r), bit_s, PARITY == PAR_ODD);
                    end
                end
                ST_STOP: begin
                    if (stb_s) begin
                        fferr_r   <= fferr_r | ~bit_s;
                        done_r    <= stop_last_s;
                        bit_cnt_r <= stop_last_s ? 4'd0 : bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    bit_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Output holding register: load on completion when free or accepted, else flag overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= 1'b0;
            data_r <= {DATA_BITS{1'b0}};
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else if (done_r && (!vld_r || rx_rdy)) begin
            vld_r  <= 1'b1;
            data_r <= shift_r;
            perr_r <= fperr_r;
            ferr_r <= fferr_r;
            ovr_r  <= 1'b0;
        end else if (done_r) begin
            ovr_r  <= 1'b1;
        end else if (vld_r && rx_rdy) begin
            vld_r  <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            ovr_r  <= 1'b0;
        end else begin
            vld_r  <= vld_r;
        end
    end

    assign rx_vld  = vld_r;
    assign rx_data = data_r;
    assign rx_perr = perr_r;
    assign rx_ferr = ferr_r;
    assign rx_ovr  = ovr_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 7E1, 8N2) at CLK_DIV=16,
// driven and sampled on the falling clock edge.
module tb_uart_rx_param;

    localparam int DIV = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DLY = 1;
`else
    localparam int MAJ_DLY = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_l  = 3'b111;
    logic [2:0] rdy_l = 3'b000;

    logic       vld0, perr0, ferr0, ovr0;
    logic [7:0] data0;
    logic       vld1, perr1, ferr1, ovr1;
    logic [6:0] data1;
    logic       vld2, perr2, ferr2, ovr2;
    logic [7:0] data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_rdy(rdy_l[0]), .rx_vld(vld0),
        .rx_data(data0), .rx_perr(perr0), .rx_ferr(ferr0), .rx_ovr(ovr0));

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut_7e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_rdy(rdy_l[1]), .rx_vld(vld1),
        .rx_data(data1), .rx_perr(perr1), .rx_ferr(ferr1), .rx_ovr(ovr1));

    uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_8n2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .rx_rdy(rdy_l[2]), .rx_vld(vld2),
        .rx_data(data2), .rx_perr(perr2), .rx_ferr(ferr2), .rx_ovr(ovr2));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nd, input logic pen,
                                             input logic pbit, input logic [1:0] stops,
                                             input int nstop);
        logic [15:0] f;
        int k;
        f    = 16'hFFFF;
        f[0] = 1'b0;
        k    = 1;
        for (int i = 0; i < nd; i++) begin
            f[k] = d[i];
            k++;
        end
        if (pen) begin
            f[k] = pbit;
            k++;
        end
        for (int i = 0; i < nstop; i++) begin
            f[k] = stops[i];
            k++;
        end
        return f;
    endfunction

    // Drives a whole frame; spike >= 0 puts a 1-clk high pulse mid-way into that line bit
    task automatic send(input int ch, input logic [8:0] d, input int nd, input logic pen,
                        input logic pbit, input logic [1:0] stops, input int nstop,
                        input int spike);
        logic [15:0] f;
        int n;
        f = mk_frame(d, nd, pen, pbit, stops, nstop);
        n = 1 + nd + (pen ? 1 : 0) + nstop;
        for (int j = 0; j < n; j++) begin
            if (j == spike) begin
                rx_l[ch] = f[j];
                repeat (9) @(negedge clk);
                rx_l[ch] = 1'b1;
                @(negedge clk);
                rx_l[ch] = f[j];
                repeat (DIV - 10) @(negedge clk);
            end else begin
                rx_l[ch] = f[j];
                repeat (DIV) @(negedge clk);
            end
        end
    endtask

    task automatic send8n1(input logic [7:0] d);
        send(0, {1'b0, d}, 8, 1'b0, 1'b0, 2'b11, 1, -1);
    endtask

    task automatic accept(input int ch);
        rdy_l[ch] = 1'b1;
        @(negedge clk);
        rdy_l[ch] = 1'b0;
    endtask

    initial begin
        logic [7:0] v;

        repeat (3) @(negedge clk);
        check("rst_vld", vld0, 1'b0);
        check("rst_data", data0, 8'h00);
        check("rst_flags", {perr0, ferr0, ovr0}, 3'b000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 basic frame held until accepted
        send8n1(8'hA5);
        check("a5_vld", vld0, 1'b1);
        check("a5_data", data0, 8'hA5);
        check("a5_flags", {perr0, ferr0, ovr0}, 3'b000);
        repeat (50) @(negedge clk);
        check("a5_hold_vld", vld0, 1'b1);
        check("a5_hold_data", data0, 8'hA5);
        accept(0);
        check("a5_acc_vld", vld0, 1'b0);
        check("a5_acc_data", data0, 8'hA5);

        // 7E1 parity
        send(1, 9'h003, 7, 1'b1, 1'b1, 2'b11, 1, -1);
        check("7e1_bad_vld", vld1, 1'b1);
        check("7e1_bad_data", data1, 7'h03);
        check("7e1_bad_perr", perr1, 1'b1);
        check("7e1_bad_ferr", {ferr1, ovr1}, 2'b00);
        accept(1);
        check("7e1_acc_perr", {vld1, perr1}, 2'b00);
        send(1, 9'h003, 7, 1'b1, 1'b0, 2'b11, 1, -1);
        check("7e1_ok_data", data1, 7'h03);
        check("7e1_ok_flags", {vld1, perr1, ferr1}, 3'b100);
        accept(1);

        // 8N2 with second stop bit low, then line stuck low
        send(2, 9'h096, 8, 1'b0, 1'b0, 2'b01, 2, -1);
        check("8n2_ferr_vld", vld2, 1'b1);
        check("8n2_ferr_data", data2, 8'h96);
        check("8n2_ferr_flags", {perr2, ferr2, ovr2}, 3'b010);
        accept(2);
        repeat (20 * DIV) @(negedge clk);
        check("8n2_low_vld", vld2, 1'b0);
        rx_l[2] = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        send(2, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 2, -1);
        check("8n2_5a_data", data2, 8'h5A);
        check("8n2_5a_flags", {vld2, perr2, ferr2, ovr2}, 4'b1000);
        accept(2);

        // Short low glitch rejected; receiver still takes the next frame
        rx_l[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check("glitch_vld", vld0, 1'b0);
        send8n1(8'h3C);
        check("post_glitch_data", {vld0, data0}, 9'h13C);
        accept(0);

`ifdef UART_RX_MAJORITY_EN
        send(0, 9'h000, 8, 1'b0, 1'b0, 2'b11, 1, 3);
        check("spike_data", {vld0, data0}, 9'h100);
        accept(0);
`endif

        // Overrun, then acceptance in the exact completion cycle
        send8n1(8'h11);
        send8n1(8'h22);
        check("ovr_data", data0, 8'h11);
        check("ovr_flags", {vld0, ovr0, perr0, ferr0}, 4'b1100);
        accept(0);
        check("ovr_clr", {vld0, ovr0}, 2'b00);
        send8n1(8'h44);
        check("held44", {vld0, ovr0, data0}, 10'h244);
        fork
            send8n1(8'h33);
            begin
                repeat (156 + MAJ_DLY) @(negedge clk);
                rdy_l[0] = 1'b1;
                @(negedge clk);
                rdy_l[0] = 1'b0;
            end
        join
        check("same_cyc_data", data0, 8'h33);
        check("same_cyc_flags", {vld0, ovr0}, 2'b10);

        // Reset in the middle of data bit 4
        v = 8'hC3;
        rx_l[0] = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_l[0] = v[i];
            repeat (DIV) @(negedge clk);
        end
        rx_l[0] = v[4];
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outs", {vld0, data0, perr0, ferr0, ovr0}, 12'h000);
        rx_l[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send8n1(8'hC3);
        check("post_rst_data", data0, 8'hC3);
        check("post_rst_flags", {vld0, perr0, ferr0, ovr0}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
